// File: rtl/reg_file_wb_ctrl_pkg.sv
// Shared definitions for the register-file writeback controller.
// Holds the default geometry, the requester-count ceiling and the register index type.
package reg_file_wb_ctrl_pkg;

   localparam int unsigned WIDTH_DEF       = 32;
   localparam int unsigned NUMREGS_DEF     = 32;
   localparam int unsigned LOG2NUMREGS_DEF = 5;
   localparam int unsigned NREQ_DEF        = 3;
   localparam int unsigned NREQ_MAX        = 8;

   typedef logic [LOG2NUMREGS_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   req         : per-requester request vector
//   advance     : a grant was taken this cycle; move the pointer past the winner
//   gnt         : one-hot grant (all zero when nothing is requested)
module rr_arbiter #(
   parameter int unsigned NREQ = 3
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] gnt
);

   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] gnt_idx;
   logic             found;

   // Scan offsets 0..NREQ-1 from ptr; the first valid requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i == ((32'(ptr) + k) % NREQ))) begin
               gnt[i]  = 1'b1;
               gnt_idx = PTR_W'(i);
               found   = 1'b1;
            end
         end
      end
   end

   // Pointer moves to the slot after the winner, wrapping at NREQ.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
   end

endmodule

// File: rtl/reg_file_wb_ctrl.sv
// Write-port scheduler and read-coherency controller for a 2R/1W register file.
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   req_valid/ready        : per-requester valid/ready writeback handshake
//   req_reg, req_data      : packed per-requester destination index and data
//   c_reg/writedatain/we   : registered register-file write port
//   a_reg/a_en, b_reg/b_en : read port indices and enables (shared with the RAM)
//   ram_a_q, ram_b_q       : raw RAM read data
//   a_data, b_data         : read data with in-flight writes bypassed in
module reg_file_wb_ctrl
   import reg_file_wb_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH       = WIDTH_DEF,
   parameter int unsigned NUMREGS     = NUMREGS_DEF,
   parameter int unsigned LOG2NUMREGS = LOG2NUMREGS_DEF,
   parameter int unsigned NREQ        = NREQ_DEF
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [NREQ-1:0]             req_valid,
   output logic [NREQ-1:0]             req_ready,
   input  logic [NREQ*LOG2NUMREGS-1:0] req_reg,
   input  logic [NREQ*WIDTH-1:0]       req_data,
   output logic [LOG2NUMREGS-1:0]      c_reg,
   output logic [WIDTH-1:0]            c_writedatain,
   output logic                        c_we,
   input  logic [LOG2NUMREGS-1:0]      a_reg,
   input  logic                        a_en,
   input  logic [LOG2NUMREGS-1:0]      b_reg,
   input  logic                        b_en,
   input  logic [WIDTH-1:0]            ram_a_q,
   input  logic [WIDTH-1:0]            ram_b_q,
   output logic [WIDTH-1:0]            a_data,
   output logic [WIDTH-1:0]            b_data
);

   logic [NREQ-1:0]        gnt;
   logic                   xfer;
   logic [LOG2NUMREGS-1:0] sel_reg;
   logic [WIDTH-1:0]       sel_data;

   logic                   a_byp, b_byp;
   logic [WIDTH-1:0]       a_byp_data, b_byp_data;
   logic [LOG2NUMREGS-1:0] a_addr_q, b_addr_q;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .resetn  (resetn),
      .req     (req_valid),
      .advance (xfer),
      .gnt     (gnt)
   );

   // No grants are offered while reset is asserted.
   assign req_ready = resetn ? gnt : '0;
   assign xfer      = |(req_valid & req_ready);

   // One-hot grant selects the winning requester's index and data.
   always_comb begin
      sel_reg  = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            sel_reg  = sel_reg  | req_reg[i*LOG2NUMREGS +: LOG2NUMREGS];
            sel_data = sel_data | req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Write stage: register 0 (and any index past the file) is accepted but not written.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         c_we          <= 1'b0;
         c_reg         <= '0;
         c_writedatain <= '0;
      end else if (xfer) begin
         c_we          <= (sel_reg != '0) && (32'(sel_reg) < NUMREGS);
         c_reg         <= sel_reg;
         c_writedatain <= sel_data;
      end else begin
         c_we          <= 1'b0;
      end
   end

   // Port a bypass: catch a write landing with the read, or later while the port is held.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         a_byp      <= 1'b0;
         a_byp_data <= '0;
         a_addr_q   <= '0;
      end else if (a_en) begin
         a_addr_q   <= a_reg;
         a_byp      <= c_we && (c_reg == a_reg) && (a_reg != '0);
         a_byp_data <= c_writedatain;
      end else if (c_we && (c_reg == a_addr_q) && (a_addr_q != '0)) begin
         a_byp      <= 1'b1;
         a_byp_data <= c_writedatain;
      end
   end

   // Port b bypass, same behaviour as port a.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         b_byp      <= 1'b0;
         b_byp_data <= '0;
         b_addr_q   <= '0;
      end else if (b_en) begin
         b_addr_q   <= b_reg;
         b_byp      <= c_we && (c_reg == b_reg) && (b_reg != '0);
         b_byp_data <= c_writedatain;
      end else if (c_we && (c_reg == b_addr_q) && (b_addr_q != '0)) begin
         b_byp      <= 1'b1;
         b_byp_data <= c_writedatain;
      end
   end

   assign a_data = a_byp ? a_byp_data : ram_a_q;
   assign b_data = b_byp ? b_byp_data : ram_b_q;

endmodule

// File: tb/tb_reg_file_wb_ctrl.sv
// Self-checking bench for reg_file_wb_ctrl: table-driven arbitration vectors with a
// write-port scoreboard, plus hand sequences for bypass and mid-run reset.
module tb_reg_file_wb_ctrl;
   import reg_file_wb_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [14:0] req_reg;
   logic [95:0] req_data;
   logic [4:0]  c_reg;
   logic [31:0] c_writedatain;
   logic        c_we;
   logic [4:0]  a_reg, b_reg;
   logic        a_en, b_en;
   logic [31:0] ram_a_q, ram_b_q;
   logic [31:0] a_data, b_data;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0]  valid;
      reg_idx_t    r0, r1, r2;
      logic [31:0] d0, d1, d2;
      logic [2:0]  exp_ready;
   } vec_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   wr_t         sb[$];
   vec_t        tbl[16];
   logic [4:0]  last_reg;
   logic [31:0] last_data;

   always #5 clk = ~clk;

   reg_file_wb_ctrl #(.WIDTH(32), .NUMREGS(32), .LOG2NUMREGS(5), .NREQ(3)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_reg(req_reg), .req_data(req_data),
      .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we),
      .a_reg(a_reg), .a_en(a_en), .b_reg(b_reg), .b_en(b_en),
      .ram_a_q(ram_a_q), .ram_b_q(ram_b_q),
      .a_data(a_data), .b_data(b_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] valid, input logic [4:0] r0, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [2:0] exp_ready);
      vec_t v;
      v.valid = valid; v.r0 = r0; v.r1 = r1; v.r2 = r2;
      v.d0 = d0; v.d1 = d1; v.d2 = d2; v.exp_ready = exp_ready;
      return v;
   endfunction

   // Drive one cycle of requests, check the grant, push the expected write, then
   // check the write port after the edge against the scoreboard.
   task automatic run_vec(input vec_t v);
      wr_t e, got;
      req_valid = v.valid;
      req_reg   = {v.r2, v.r1, v.r0};
      req_data  = {v.d2, v.d1, v.d0};
      #1;
      check("req_ready", 32'(req_ready), 32'(v.exp_ready));
      e.we = 1'b0; e.r = last_reg; e.d = last_data;
      if (v.exp_ready == 3'b001) begin e.r = v.r0; e.d = v.d0; e.we = (v.r0 != 5'd0); end
      if (v.exp_ready == 3'b010) begin e.r = v.r1; e.d = v.d1; e.we = (v.r1 != 5'd0); end
      if (v.exp_ready == 3'b100) begin e.r = v.r2; e.d = v.d2; e.we = (v.r2 != 5'd0); end
      last_reg  = e.r;
      last_data = e.d;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         got = sb.pop_front();
         check("c_we", 32'(c_we), 32'(got.we));
         check("c_reg", 32'(c_reg), 32'(got.r));
         check("c_writedatain", c_writedatain, got.d);
      end
   endtask

   function automatic vec_t idle();
      return mk(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b000);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn    = 1'b0;
      req_valid = 3'b111;
      req_reg   = {5'd3, 5'd2, 5'd1};
      req_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      a_en = 1'b0; b_en = 1'b0; a_reg = 5'd0; b_reg = 5'd0;
      ram_a_q = 32'h0A0A_0A0A;
      ram_b_q = 32'h0B0B_0B0B;

      // Reset held three cycles with all requesters valid.
      repeat (3) begin
         @(posedge clk);
         #1;
         check("rst_req_ready", 32'(req_ready), 32'd0);
         check("rst_c_we", 32'(c_we), 32'd0);
         check("rst_c_reg", 32'(c_reg), 32'd0);
         check("rst_c_data", c_writedatain, 32'd0);
         check("rst_a_data", a_data, ram_a_q);
         check("rst_b_data", b_data, ram_b_q);
      end
      resetn    = 1'b1;
      last_reg  = 5'd0;
      last_data = 32'd0;

      tbl[0]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3'b001);
      tbl[1]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3'b010);
      tbl[2]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3'b100);
      tbl[3]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3'b001);
      tbl[4]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3'b010);
      tbl[5]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 3'b100);
      tbl[6]  = mk(3'b010, 5'd0, 5'd0, 5'd0, 32'd0, 32'hDEAD_BEEF, 32'd0, 3'b010);
      tbl[7]  = mk(3'b100, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h9000_0001, 3'b100);
      tbl[8]  = mk(3'b100, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h9000_0002, 3'b100);
      tbl[9]  = mk(3'b100, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h9000_0003, 3'b100);
      tbl[10] = mk(3'b100, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h9000_0004, 3'b100);
      tbl[11] = mk(3'b101, 5'd10, 5'd0, 5'd12, 32'hA0A0_0010, 32'd0, 32'hC0C0_0012, 3'b001);
      tbl[12] = mk(3'b101, 5'd10, 5'd0, 5'd12, 32'hA0A0_0010, 32'd0, 32'hC0C0_0012, 3'b100);
      tbl[13] = idle();
      tbl[14] = mk(3'b011, 5'd13, 5'd14, 5'd0, 32'hD000_0013, 32'hE000_0014, 32'd0, 3'b001);
      tbl[15] = mk(3'b011, 5'd13, 5'd14, 5'd0, 32'hD000_0013, 32'hE000_0014, 32'd0, 3'b010);

      for (int i = 0; i < 16; i++) run_vec(tbl[i]);

      // Write r5 lands at the same edge as a read of r5 on port a.
      run_vec(mk(3'b001, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 32'd0, 32'd0, 3'b001));
      a_en = 1'b1; a_reg = 5'd5; ram_a_q = 32'd0;
      b_en = 1'b1; b_reg = 5'd8;
      run_vec(idle());
      check("same_edge_a", a_data, 32'h1234_5678);
      check("no_byp_b", b_data, ram_b_q);

      // Read r7, hold the port, then a later write to r7 must appear.
      a_reg = 5'd7; b_en = 1'b0; ram_a_q = 32'h7777_7777;
      run_vec(idle());
      check("read_r7", a_data, 32'h7777_7777);
      a_en = 1'b0;
      run_vec(idle());
      run_vec(idle());
      run_vec(mk(3'b001, 5'd7, 5'd0, 5'd0, 32'hA5A5_A5A5, 32'd0, 32'd0, 3'b001));
      check("held_before_byp", a_data, 32'h7777_7777);
      run_vec(idle());
      check("held_byp_a", a_data, 32'hA5A5_A5A5);
      run_vec(mk(3'b001, 5'd8, 5'd0, 5'd0, 32'h8888_8888, 32'd0, 32'd0, 3'b001));
      run_vec(idle());
      check("other_reg_a", a_data, 32'hA5A5_A5A5);
      check("held_byp_b", b_data, 32'h8888_8888);

      // Reset mid-operation: registered write stays visible, pointer restarts at 0.
      ram_a_q = 32'h1212_1212;
      run_vec(mk(3'b001, 5'd3, 5'd0, 5'd0, 32'h3333_0003, 32'd0, 32'd0, 3'b001));
      resetn    = 1'b0;
      req_valid = 3'b101;
      req_reg   = {5'd6, 5'd0, 5'd4};
      req_data  = {32'h6666_0006, 32'd0, 32'h4444_0004};
      #1;
      check("midrst_ready", 32'(req_ready), 32'd0);
      check("midrst_c_we_kept", 32'(c_we), 32'd1);
      check("midrst_c_reg_kept", 32'(c_reg), 32'd3);
      @(posedge clk);
      #1;
      check("midrst_c_we", 32'(c_we), 32'd0);
      check("midrst_c_reg", 32'(c_reg), 32'd0);
      check("midrst_c_data", c_writedatain, 32'd0);
      check("midrst_a_data", a_data, 32'h1212_1212);
      resetn    = 1'b1;
      last_reg  = 5'd0;
      last_data = 32'd0;
      run_vec(mk(3'b101, 5'd4, 5'd0, 5'd6, 32'h4444_0004, 32'd0, 32'h6666_0006, 3'b001));
      run_vec(mk(3'b101, 5'd4, 5'd0, 5'd6, 32'h4444_0004, 32'd0, 32'h6666_0006, 3'b100));
      run_vec(idle());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
